// File: rtl/mips_pkg.sv
// Shared MIPS constants: opcodes, functs, fetch state encoding
// and the default reset PC.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FS_REQ   = 1'b0,
        FS_VALID = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC: jump beats taken branch beats PC+4.
// Result is always word-aligned.
module next_pc_calc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] instr_pc,
    input  logic              br_taken,
    input  logic [15:0]       br_imm,
    input  logic              jmp,
    input  logic [25:0]       jmp_idx,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] target;

    always_comb begin
        pc4    = instr_pc + ADDR_W'(4);
        br_off = {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};
        if (jmp) begin
            target = {pc4[ADDR_W-1:28], jmp_idx, 2'b00};
        end else if (br_taken) begin
            target = pc4 + br_off;
        end else begin
            target = pc4;
        end
        next_pc = {target[ADDR_W-1:2], 2'b00};
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one-in-flight imem req/ack, valid/ready to decode.
// Optional FETCH_STATS_EN adds stall_cycles / fetched_count.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              br_taken,
    input  logic [15:0]       br_imm,
    input  logic              jmp,
    input  logic [25:0]       jmp_idx
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       fetched_count
`endif
);

    localparam logic [ADDR_W-1:0] RST_PC = {RESET_PC[ADDR_W-1:2], 2'b00};

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] next_pc;
    logic              in_req, in_valid;

    assign in_req   = (state_q == FS_REQ);
    assign in_valid = (state_q == FS_VALID);

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .instr_pc (instr_pc_q),
        .br_taken (br_taken),
        .br_imm   (br_imm),
        .jmp      (jmp),
        .jmp_idx  (jmp_idx),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        instr_d    = instr_q;
        unique case (state_q)
            FS_REQ: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = FS_VALID;
                end
            end
            FS_VALID: begin
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FS_REQ;
            pc_q       <= RST_PC;
            instr_pc_q <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            instr_q    <= instr_d;
        end
    end

    // Request is masked by reset so it drops the moment rst_n falls.
    assign imem_req    = in_req & rst_n;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = in_valid;

`ifdef FETCH_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] fetched_q, fetched_d;

    always_comb begin
        stall_d   = stall_q;
        fetched_d = fetched_q;
        if (((in_req && !imem_ack) || (in_valid && !instr_ready))
            && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
        if (in_valid && instr_ready && fetched_q != '1) begin
            fetched_d = fetched_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q   <= '0;
            fetched_q <= '0;
        end else begin
            stall_q   <= stall_d;
            fetched_q <= fetched_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign fetched_count = fetched_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized
// run checked against an arithmetic next-PC model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_imm = '0;
    logic        jmp = 1'b0;
    logic [25:0] jmp_idx = '0;

    logic        imem_req, imem_req_w;
    logic [31:0] imem_addr, imem_addr_w;
    logic [31:0] instr, instr_w;
    logic [31:0] instr_pc, instr_pc_w;
    logic        instr_valid, instr_valid_w;
`ifdef FETCH_STATS_EN
    logic [31:0] stall_cycles, fetched_count, stall_w, fetched_w;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .br_taken(br_taken), .br_imm(br_imm),
        .jmp(jmp), .jmp_idx(jmp_idx)
`ifdef FETCH_STATS_EN
        , .stall_cycles(stall_cycles), .fetched_count(fetched_count)
`endif
    );

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr_w), .instr_pc(instr_pc_w),
        .instr_valid(instr_valid_w), .instr_ready(instr_ready),
        .br_taken(br_taken), .br_imm(br_imm),
        .jmp(jmp), .jmp_idx(jmp_idx)
`ifdef FETCH_STATS_EN
        , .stall_cycles(stall_w), .fetched_count(fetched_w)
`endif
    );

    function automatic logic [31:0] model_next(
        input logic [31:0] pc, input logic b, input logic [15:0] imm,
        input logic j, input logic [25:0] idx);
        logic [31:0] pc4;
        int          off;
        pc4 = pc + 32'd4;
        if (j) return (pc4 & 32'hF000_0000) | ({6'b0, idx} * 32'd4);
        if (b) begin
            off = int'($signed(imm)) * 4;
            return pc4 + 32'(off);
        end
        return pc4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack = 0; instr_ready = 0; br_taken = 0;
        br_imm = '0; jmp = 0; jmp_idx = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        #1;
    endtask

    task automatic drive_fetch(input logic [31:0] w, input int ad, input int rd,
        input logic b, input logic [15:0] imm, input logic j, input logic [25:0] idx);
        imem_ack = 0;
        repeat (ad) tick();
        imem_ack = 1; imem_rdata = w;
        tick();
        imem_ack = 0; instr_ready = 0;
        repeat (rd) tick();
        instr_ready = 1; br_taken = b; br_imm = imm; jmp = j; jmp_idx = idx;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        rst_n = 0; imem_ack = 1;
        tick();
        compared++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ctl: req=%b valid=%b want 0 0", imem_req, instr_valid);
        end
        compared++;
        if (instr !== 32'h0 || instr_pc !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_regs: instr=%h pc=%h want 0 0", instr, instr_pc);
        end
        imem_ack = 0;
        rst_n = 1;
        #1;
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_release: req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
        compared++;
        if (imem_addr_w !== 32'hFFFF_FFFC) begin
            mismatched++;
            $display("FAIL reset_pc_param: got %h want fffffffc", imem_addr_w);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] w;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin
                mismatched++;
                $display("FAIL seq_addr%0d: req=%b addr=%h want 1 %h",
                         i, imem_req, imem_addr, 32'(i * 4));
            end
            w = $urandom;
            imem_ack = 1; imem_rdata = w;
            tick();
            imem_ack = 0;
            compared++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0
                || instr !== w || instr_pc !== 32'(i * 4)) begin
                mismatched++;
                $display("FAIL seq_valid%0d: v=%b req=%b instr=%h pc=%h want 1 0 %h %h",
                         i, instr_valid, imem_req, instr, instr_pc, w, 32'(i * 4));
            end
            instr_ready = 1;
            tick();
            instr_ready = 0;
        end
    endtask

    task automatic test_branch();
        drive_fetch(32'h1, 0, 0, 0, 16'h0, 0, 26'h0);
        compared++;
        if (imem_addr !== 32'h10) begin
            mismatched++;
            $display("FAIL br_setup: got %h want 00000010", imem_addr);
        end
        drive_fetch(32'h2, 0, 0, 1, 16'hFFFC, 0, 26'h0);
        compared++;
        if (imem_addr !== 32'h04) begin
            mismatched++;
            $display("FAIL br_back: got %h want 00000004", imem_addr);
        end
        drive_fetch(32'h3, 0, 0, 1, 16'h0002, 0, 26'h0);
        drive_fetch(32'h4, 0, 0, 1, 16'h0003, 0, 26'h0);
        compared++;
        if (imem_addr !== 32'h20) begin
            mismatched++;
            $display("FAIL br_fwd: got %h want 00000020", imem_addr);
        end
    endtask

    task automatic test_jump();
        drive_fetch(32'h5, 0, 0, 0, 16'h0, 1, 26'h3FF_FFFF);
        compared++;
        if (imem_addr !== 32'h0FFF_FFFC) begin
            mismatched++;
            $display("FAIL jmp_max: got %h want 0ffffffc", imem_addr);
        end
        drive_fetch(32'h6, 0, 0, 0, 16'h0, 1, 26'h10);
        imem_ack = 1; imem_rdata = 32'h7;
        tick();
        imem_ack = 0;
        compared++;
        if (instr_pc !== 32'h1000_0040) begin
            mismatched++;
            $display("FAIL jmp_region: got %h want 10000040", instr_pc);
        end
        instr_ready = 1; jmp = 1; jmp_idx = 26'h100; br_taken = 1; br_imm = 16'hFFFC;
        tick();
        clear_inputs();
        compared++;
        if (imem_addr !== 32'h1000_0400) begin
            mismatched++;
            $display("FAIL jmp_prio: got %h want 10000400", imem_addr);
        end
    endtask

    task automatic test_stall();
        logic [31:0] w;
        w = $urandom;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            instr_ready = 1; jmp = 1; jmp_idx = 26'h2A;
            compared++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL stall_req%0d: req=%b addr=%h v=%b want 1 0 0",
                         i, imem_req, imem_addr, instr_valid);
            end
            tick();
        end
        clear_inputs();
        imem_ack = 1; imem_rdata = w;
        tick();
        imem_rdata = ~w;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (instr_valid !== 1'b1 || instr !== w || instr_pc !== 32'h0) begin
                mismatched++;
                $display("FAIL stall_hold%0d: v=%b instr=%h pc=%h want 1 %h 0",
                         i, instr_valid, instr, instr_pc, w);
            end
            tick();
        end
        imem_ack = 0;
        instr_ready = 1;
        tick();
        instr_ready = 0;
        compared++;
        if (imem_addr !== 32'h4 || instr !== w) begin
            mismatched++;
            $display("FAIL stall_done: addr=%h instr=%h want 4 %h", imem_addr, instr, w);
        end
`ifdef FETCH_STATS_EN
        compared++;
        if (stall_cycles !== 32'd8 || fetched_count !== 32'd1) begin
            mismatched++;
            $display("FAIL stats: stall=%0d fetched=%0d want 8 1",
                     stall_cycles, fetched_count);
        end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        drive_fetch(32'h9, 1, 1, 0, 16'h0, 0, 26'h0);
        compared++;
        if (imem_addr_w !== 32'h0 || instr_pc_w !== 32'hFFFF_FFFC) begin
            mismatched++;
            $display("FAIL wrap: addr=%h pc=%h want 0 fffffffc", imem_addr_w, instr_pc_w);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w1;
        w1 = $urandom;
        do_reset();
        imem_ack = 1; imem_rdata = 32'h11;
        tick();
        imem_ack = 0;
        #2 rst_n = 0;
        #1;
        compared++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 32'h0) begin
            mismatched++;
            $display("FAIL rst_in_valid: v=%b req=%b instr=%h want 0 0 0",
                     instr_valid, imem_req, instr);
        end
        tick();
        rst_n = 1;
        #1;
        drive_fetch(32'h12, 0, 0, 0, 16'h0, 0, 26'h0);
        compared++;
        if (imem_addr !== 32'h4) begin
            mismatched++;
            $display("FAIL rst_pre_req: got %h want 4", imem_addr);
        end
        #2 rst_n = 0;
        #1;
        compared++;
        if (imem_req !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_in_req: req=%b want 0", imem_req);
        end
        tick();
        rst_n = 1;
        #1;
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_restart: req=%b addr=%h v=%b want 1 0 0",
                     imem_req, imem_addr, instr_valid);
        end
        imem_ack = 1; imem_rdata = w1;
        tick();
        imem_rdata = ~w1;
        repeat (2) tick();
        imem_ack = 0;
        compared++;
        if (instr_valid !== 1'b1 || instr !== w1 || instr_pc !== 32'h0) begin
            mismatched++;
            $display("FAIL spurious_ack: v=%b instr=%h pc=%h want 1 %h 0",
                     instr_valid, instr, instr_pc, w1);
        end
        instr_ready = 1;
        tick();
        instr_ready = 0;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, w;
        logic        b, j;
        logic [15:0] imm;
        logic [25:0] idx;
        int          ad, rd;
        do_reset();
        exp_pc = 32'h0;
        for (int n = 0; n < 30; n++) begin
            ad = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            w = $urandom;
            b = 1'($urandom_range(0, 1));
            j = ($urandom_range(0, 3) == 0);
            imm = 16'($urandom);
            idx = 26'($urandom);
            compared++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
                mismatched++;
                $display("FAIL rnd_addr%0d: req=%b addr=%h want 1 %h",
                         n, imem_req, imem_addr, exp_pc);
            end
            repeat (ad) begin
                instr_ready = 1'($urandom_range(0, 1));
                jmp = 1'($urandom_range(0, 1));
                br_taken = 1'($urandom_range(0, 1));
                tick();
            end
            imem_ack = 1; imem_rdata = w;
            tick();
            imem_ack = 0; instr_ready = 0;
            compared++;
            if (instr_valid !== 1'b1 || instr !== w || instr_pc !== exp_pc) begin
                mismatched++;
                $display("FAIL rnd_instr%0d: v=%b instr=%h pc=%h want 1 %h %h",
                         n, instr_valid, instr, instr_pc, w, exp_pc);
            end
            repeat (rd) begin
                jmp = 1'($urandom_range(0, 1));
                br_taken = 1'($urandom_range(0, 1));
                br_imm = 16'($urandom);
                tick();
            end
            instr_ready = 1; br_taken = b; br_imm = imm; jmp = j; jmp_idx = idx;
            tick();
            clear_inputs();
            exp_pc = model_next(exp_pc, b, imm, j, idx);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
